fpdiv_iter: RTL and testbench

FPDIV_ITER -- requirements
Module: fpdiv_iter

---
 rtl/fpdiv_iter.sv | 186 ++++++++++++++++++
 tb/tb_fpdiv_iter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_iter.sv
`default_nettype none
// fpdiv_iter: iterative divider for a 13-bit float (sign, 4-bit exponent bias 7, U(8.7) mantissa).
// Optional macro FPDIV_ROUND_EN adds a round-to-nearest stage after the restoring divide.
module fpdiv_iter (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [12:0] i_data1,
  input  logic [12:0] i_data2,
  output logic        o_busy,
  output logic        o_done,
  output logic [12:0] o_result
);

  localparam logic [12:0] NAN_VAL  = 13'h1F80;
  localparam logic [11:0] INF_MAG  = 12'hF00;
  localparam logic [11:0] ZERO_MAG = 12'h700;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [5:0]  exp_q, exp_d;
  logic [7:0]  dvs_q, dvs_d;
  logic [14:0] dvd_q, dvd_d;
  logic [7:0]  quo_q, quo_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  rem_q, rem_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [12:0] res_q, res_d;

  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_m0, b_m0;
  logic        s_in, special;
  logic [12:0] special_res;
  logic [8:0]  trial, trial_sub;
  logic        fits;
  logic [7:0]  next_rem, next_quo;
  logic        next_ovf;

  // Pack sign/exponent/quotient into the output format, applying range clamps.
  function automatic logic [12:0] pack(input logic s, input logic [5:0] e, input logic ovf,
                                       input logic [7:0] q, input logic [7:0] r,
                                       input logic [7:0] m, input logic rnd);
    logic [7:0] mant;
    mant = ovf ? 8'hFF : q;
    if (rnd && ({r, 1'b0} >= {1'b0, m}) && (mant != 8'hFF))
      mant = mant + 8'd1;
    if (e[5])
      pack = {s, ZERO_MAG};
    else if (e > 6'd14)
      pack = {s, INF_MAG};
    else
      pack = {s, e[3:0], mant};
  endfunction

  always_comb begin
    a_nan  = (i_data1 == NAN_VAL);
    b_nan  = (i_data2 == NAN_VAL);
    a_inf  = (i_data1[11:8] == 4'hF) && !a_nan;
    b_inf  = (i_data2[11:8] == 4'hF) && !b_nan;
    a_zero = (i_data1[11:0] == ZERO_MAG);
    b_zero = (i_data2[11:0] == ZERO_MAG);
    a_m0   = (i_data1[7:0] == 8'h00);
    b_m0   = (i_data2[7:0] == 8'h00);
    s_in   = i_data1[12] ^ i_data2[12];
    special     = 1'b1;
    special_res = NAN_VAL;
    if (a_nan || b_nan)
      special_res = NAN_VAL;
    else if ((a_zero && b_zero) || (a_inf && b_inf))
      special_res = NAN_VAL;
    else if (b_zero || b_m0)
      special_res = {s_in, INF_MAG};
    else if (a_zero || a_m0)
      special_res = {s_in, ZERO_MAG};
    else if (a_inf)
      special_res = {s_in, INF_MAG};
    else if (b_inf)
      special_res = {s_in, ZERO_MAG};
    else
      special = 1'b0;
  end

  // One restoring step; a quotient bit leaving the 8-bit window means q > 255.
  always_comb begin
    trial     = {rem_q, dvd_q[14]};
    fits      = (trial >= {1'b0, dvs_q});
    trial_sub = trial - {1'b0, dvs_q};
    next_rem  = fits ? trial_sub[7:0] : trial[7:0];
    next_quo  = {quo_q[6:0], fits};
    next_ovf  = ovf_q | quo_q[7];
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          sign_d = s_in;
          exp_d  = {2'b00, i_data1[11:8]} - {2'b00, i_data2[11:8]} + 6'd7;
          dvs_d  = i_data2[7:0];
          dvd_d  = {i_data1[7:0], 7'b0};
          quo_d  = 8'h00;
          ovf_d  = 1'b0;
          rem_d  = 8'h00;
          cnt_d  = 4'd0;
          if (special) begin
            res_d   = special_res;
            state_d = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        dvd_d = {dvd_q[13:0], 1'b0};
        quo_d = next_quo;
        ovf_d = next_ovf;
        rem_d = next_rem;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd14) begin
`ifdef FPDIV_ROUND_EN
          state_d = ROUND;
`else
          res_d   = pack(sign_q, exp_q, next_ovf, next_quo, next_rem, dvs_q, 1'b0);
          state_d = DONE;
`endif
        end
      end
      ROUND: begin
`ifdef FPDIV_ROUND_EN
        res_d = pack(sign_q, exp_q, ovf_q, quo_q, rem_q, dvs_q, 1'b1);
`endif
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= 6'd0;
      dvs_q   <= 8'h00;
      dvd_q   <= 15'h0000;
      quo_q   <= 8'h00;
      ovf_q   <= 1'b0;
      rem_q   <= 8'h00;
      cnt_q   <= 4'd0;
      res_q   <= 13'h0000;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == DONE);
  assign o_result = res_q;

endmodule
`default_nettype wire

// File: tb/tb_fpdiv_iter.sv
`default_nettype none
// tb_fpdiv_iter: scoreboard-based self-checking bench for fpdiv_iter.
module tb_fpdiv_iter;

`ifdef FPDIV_ROUND_EN
  localparam bit ROUND_ON = 1'b1;
`else
  localparam bit ROUND_ON = 1'b0;
`endif
  localparam int NORM_LAT = ROUND_ON ? 17 : 16;
  localparam logic [12:0] R_0790 = ROUND_ON ? 13'h0772 : 13'h0771;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] d1 = 13'h0;
  logic [12:0] d2 = 13'h0;
  logic        busy, done;
  logic [12:0] result;

  always #5 clk = ~clk;

  fpdiv_iter dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .i_start (start),
    .i_data1 (d1),
    .i_data2 (d2),
    .o_busy  (busy),
    .o_done  (done),
    .o_result(result)
  );

  typedef struct {
    logic [12:0] res;
    int          lat;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     passed = 0;
  longint t0;

  function automatic logic [12:0] model(input logic [12:0] a, input logic [12:0] b);
    int   ma, mb, q, r, m, e;
    logic s;
    ma = int'(a[7:0]);
    mb = int'(b[7:0]);
    s  = a[12] ^ b[12];
    q  = (ma * 128) / mb;
    r  = (ma * 128) % mb;
    m  = (q > 255) ? 255 : q;
    if (ROUND_ON && (2 * r >= mb) && (m < 255)) m = m + 1;
    e = int'(a[11:8]) - int'(b[11:8]) + 7;
    if (e > 14) return {s, 12'hF00};
    if (e < 0) return {s, 12'h700};
    return {s, e[3:0], m[7:0]};
  endfunction

  // Drive one request; operands are scrambled right after the sample edge.
  task automatic issue(input logic [12:0] a, input logic [12:0] b,
                       input logic [12:0] eres, input int elat, input bit push);
    exp_t e;
    @(negedge clk);
    d1 = a;
    d2 = b;
    start = 1'b1;
    e.res = eres;
    e.lat = elat;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    t0 = $time;
    start = 1'b0;
    d1 = 13'($urandom);
    d2 = 13'($urandom);
  endtask

  task automatic wait_done(input string name);
    exp_t e;
    int   lat;
    int   n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = int'(($time - t0) / 10) + 1;
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1)
      $display("FAIL %s done: not seen after %0d cycles, required latency %0d", name, lat, e.lat);
    else if (lat != e.lat)
      $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
    else
      passed++;
    checks++;
    if (result !== e.res)
      $display("FAIL %s result: got %h required %h", name, result, e.res);
    else
      passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b required 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset done: got %b required 0", done); else passed++;
    checks++; if (result !== 13'h0) $display("FAIL reset result: got %h required 0000", result); else passed++;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    logic [12:0] held;
    issue(13'h0880, 13'h0780, 13'h0880, NORM_LAT, 1'b1);
    checks++; if (busy !== 1'b1) $display("FAIL busy_during_op: got %b required 1", busy); else passed++;
    wait_done("2.0/1.0");
    issue(13'h0780, 13'h1880, 13'h1680, NORM_LAT, 1'b1);
    wait_done("1.0/-2.0");
    issue(13'h0780, 13'h0790, R_0790, NORM_LAT, 1'b1);
    wait_done("1.0/0x90");
    held = R_0790;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (result !== held) $display("FAIL result_hold: got %h required %h", result, held); else passed++;
  endtask

  task automatic test_special();
    logic [12:0] va[8] = '{13'h0700, 13'h0780, 13'h1F80, 13'h0F80, 13'h0780, 13'h1F00, 13'h0700, 13'h1880};
    logic [12:0] vb[8] = '{13'h0700, 13'h0700, 13'h0780, 13'h0780, 13'h0F80, 13'h0F00, 13'h0780, 13'h0700};
    logic [12:0] vr[8] = '{13'h1F80, 13'h0F00, 13'h1F80, 13'h0F00, 13'h0700, 13'h1F80, 13'h0700, 13'h1F00};
    for (int i = 0; i < 8; i++) begin
      issue(va[i], vb[i], vr[i], 1, 1'b1);
      wait_done($sformatf("special%0d", i));
    end
  endtask

  task automatic test_range();
    issue(13'h0E80, 13'h0080, 13'h0F00, NORM_LAT, 1'b1);
    wait_done("overflow");
    issue(13'h0080, 13'h0E80, 13'h0700, NORM_LAT, 1'b1);
    wait_done("underflow");
    issue(13'h07FF, 13'h0701, 13'h07FF, NORM_LAT, 1'b1);
    wait_done("saturation");
  endtask

  task automatic test_random();
    logic [12:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = {1'($urandom), 4'($urandom_range(0, 14)), 8'($urandom_range(1, 255))};
      b = {1'($urandom), 4'($urandom_range(0, 14)), 8'($urandom_range(1, 255))};
      issue(a, b, model(a, b), NORM_LAT, 1'b1);
      wait_done($sformatf("rand %h/%h", a, b));
    end
  endtask

  task automatic test_midreset();
    int ndone;
    issue(13'h0880, 13'h0780, 13'h0880, NORM_LAT, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL midreset busy: got %b required 0", busy); else passed++;
    checks++; if (result !== 13'h0) $display("FAIL midreset result: got %h required 0000", result); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL midreset done: got %b required 0", done); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) $display("FAIL midreset no_done: got %0d pulses required 0", ndone); else passed++;
  endtask

  task automatic test_busy_ignore();
    int ndone;
    issue(13'h0780, 13'h0790, R_0790, NORM_LAT, 1'b1);
    for (int k = 0; k < 2; k++) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      d1 = 13'h0880;
      d2 = 13'h0780;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("busy_ignore");
    ndone = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) ndone++;
    end
    checks++; if (ndone != 0) $display("FAIL busy_ignore extra_done: got %0d pulses required 0", ndone); else passed++;
    checks++; if (result !== R_0790) $display("FAIL busy_ignore held: got %h required %h", result, R_0790); else passed++;
  endtask

  task automatic test_back_to_back();
    int first, second, ndone;
    logic [12:0] exp_r;
    exp_r = model(13'h0780, 13'h0790);
    first = 0;
    second = 0;
    ndone = 0;
    @(negedge clk);
    d1 = 13'h0780;
    d2 = 13'h0790;
    start = 1'b1;
    for (int c = 1; c <= 2 * NORM_LAT + 2; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) first = c;
        if (ndone == 2) second = c;
      end
    end
    start = 1'b0;
    checks++; if (ndone != 2) $display("FAIL b2b count: got %0d required 2", ndone); else passed++;
    checks++; if (first != NORM_LAT) $display("FAIL b2b first: got %0d required %0d", first, NORM_LAT); else passed++;
    checks++; if (second != 2 * NORM_LAT + 1) $display("FAIL b2b second: got %0d required %0d", second, 2 * NORM_LAT + 1); else passed++;
    checks++; if (result !== exp_r) $display("FAIL b2b result: got %h required %h", result, exp_r); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL b2b idle: got busy %b required 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_random();
    test_midreset();
    test_busy_ignore();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
